// File: rtl/pci_target_decoder.sv
// pci_target_decoder
//   PCI target-side address/command decoder and DEVSEL/TRDY sequencer.
//   Latches address/command on the address phase and claims the transaction
//   when the address falls in the single BAR window and the command is an
//   I/O or memory read/write. It then sequences the data phases: TRDY
//   handshake, burst counting, target disconnect (STOP) and a one-cycle
//   turnaround.
//
// Optional feature (macro PCI_PARITY_CHK_EN):
//   defined   -> even parity of {ad, c_be} from the claimed address phase and
//                from each write-data transfer is checked against par on the
//                following cycle; a mismatch gives a one-cycle perr pulse.
//   undefined -> par is ignored and perr is tied 0.
//
// Ports:
//   clk       in   bus clock, rising edge
//   rst_n     in   synchronous reset, active-low
//   frame     in   initiator FRAME (1 = transaction in progress)
//   irdy      in   initiator ready
//   ad[31:0]  in   address/data bus (address sampled)
//   c_be[3:0] in   command / byte enables
//   par       in   even parity over ad and c_be, one cycle late
//   devsel    out  device select (registered)
//   trdy      out  target ready (registered)
//   stop      out  target disconnect request (registered)
//   hit_addr  out  latched address of the claimed transaction
//   hit_cmd   out  latched command of the claimed transaction
//   is_write  out  1 = claimed command is a write
//   data_cnt  out  completed data phases in the current transaction
//   perr      out  parity error pulse
module pci_target_decoder #(
  parameter logic [31:0] BAR_BASE     = 32'h0000_1000,
  parameter logic [31:0] BAR_MASK     = 32'hFFFF_F000,
  parameter int          DEVSEL_SPEED = 0,
  parameter int          MAX_BURST    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame,
  input  logic        irdy,
  input  logic [31:0] ad,
  input  logic [3:0]  c_be,
  input  logic        par,
  output logic        devsel,
  output logic        trdy,
  output logic        stop,
  output logic [31:0] hit_addr,
  output logic [3:0]  hit_cmd,
  output logic        is_write,
  output logic [3:0]  data_cnt,
  output logic        perr
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY   = 3'd1,
    ST_DECODE = 3'd2,
    ST_DATA   = 3'd3,
    ST_DISC   = 3'd4,
    ST_TURN   = 3'd5
  } state_t;

  localparam logic [1:0] WAIT_INIT_C = 2'(DEVSEL_SPEED);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_t      state_r, state_s;
  logic        frame_q_r;
  logic [1:0]  wait_cnt_r, wait_cnt_s;
  logic [3:0]  data_cnt_r, data_cnt_s;
  logic        devsel_r, trdy_r, stop_r;
  logic [31:0] hit_addr_r;
  logic [3:0]  hit_cmd_r;
  logic        is_write_r;
  logic        addr_phase_s, addr_match_s, cmd_ok_s, hit_s, xfer_s;

  // Address-phase detection, BAR compare, command filter and transfer strobe.
  always_comb begin
    addr_phase_s = (state_r == ST_IDLE) && frame && !frame_q_r;
    addr_match_s = ((ad & BAR_MASK) == BAR_BASE);
    case (c_be)
      4'b0010, 4'b0011, 4'b0110, 4'b0111: cmd_ok_s = 1'b1;
      default:                            cmd_ok_s = 1'b0;
    endcase
    hit_s  = addr_match_s && cmd_ok_s;
    xfer_s = (state_r == ST_DATA) && irdy && trdy_r;
  end

  // Next-state logic for the transaction sequencer and its counters.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    data_cnt_s = data_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (addr_phase_s && hit_s) begin
          state_s    = ST_DECODE;
          wait_cnt_s = WAIT_INIT_C;
          data_cnt_s = 4'd0;
        end else if (addr_phase_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!frame && !irdy) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DECODE: begin
        // Wait count of zero on entry means devsel on the very next edge.
        if (wait_cnt_r == 2'd0) begin
          state_s = ST_DATA;
        end else begin
          wait_cnt_s = wait_cnt_r - 2'd1;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          data_cnt_s = data_cnt_r + 4'd1;
          if (!frame) begin
            state_s = ST_TURN;
          end else if ((data_cnt_r + 4'd1) == MAX_BURST_C) begin
            state_s = ST_DISC;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DISC: begin
        if (!frame) begin
          state_s = ST_TURN;
        end else begin
          state_s = ST_DISC;
        end
      end
      ST_TURN: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters, registered bus outputs and claimed-transaction latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      frame_q_r  <= 1'b0;
      wait_cnt_r <= 2'd0;
      data_cnt_r <= 4'd0;
      devsel_r   <= 1'b0;
      trdy_r     <= 1'b0;
      stop_r     <= 1'b0;
      hit_addr_r <= 32'd0;
      hit_cmd_r  <= 4'd0;
      is_write_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      frame_q_r  <= frame;
      wait_cnt_r <= wait_cnt_s;
      data_cnt_r <= data_cnt_s;
      // Outputs follow the state being entered so they line up with it.
      devsel_r   <= (state_s == ST_DATA) || (state_s == ST_DISC);
      trdy_r     <= (state_s == ST_DATA);
      stop_r     <= (state_s == ST_DISC);
      if (addr_phase_s && hit_s) begin
        hit_addr_r <= ad;
        hit_cmd_r  <= c_be;
        is_write_r <= c_be[0];
      end
    end
  end

  assign devsel   = devsel_r;
  assign trdy     = trdy_r;
  assign stop     = stop_r;
  assign hit_addr = hit_addr_r;
  assign hit_cmd  = hit_cmd_r;
  assign is_write = is_write_r;
  assign data_cnt = data_cnt_r;

`ifdef PCI_PARITY_CHK_EN
  function automatic logic even_parity(input logic [35:0] vec);
    return ^vec;
  endfunction

  logic par_pend_r, par_exp_r, perr_r;

  // Capture expected parity of claimed address/write-data cycles, check next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_pend_r <= 1'b0;
      par_exp_r  <= 1'b0;
      perr_r     <= 1'b0;
    end else begin
      par_pend_r <= (addr_phase_s && hit_s) || (xfer_s && is_write_r);
      par_exp_r  <= even_parity({ad, c_be});
      perr_r     <= par_pend_r && (par != par_exp_r);
    end
  end

  assign perr = perr_r;
`else
  logic par_unused_s;
  assign par_unused_s = par;
  assign perr         = 1'b0;
`endif

endmodule

// File: doc/pci_target_decoder.md
Name: pci_target_decoder

Overview:
- PCI target-side address/command decoder and DEVSEL/TRDY sequencer.
- Sits directly upstream of the read/write command block and produces the `devsel` qualifier that block consumes.
- Latches address and command on the address phase, checks the address against one BAR window, then sequences data phases: TRDY handshake, burst counting, disconnect (STOP) and turnaround.

Parameters:
- BAR_BASE, 32'h0000_1000, base address of the claimed window.
- BAR_MASK, 32'hFFFF_F000, compare mask; hit when (ad & BAR_MASK) == BAR_BASE.
- DEVSEL_SPEED, 0, extra decode wait cycles before devsel is asserted (0 = fast, 1 = medium, 2 = slow).
- MAX_BURST, 8, maximum data phases per transaction before a target disconnect; range 1..15.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- frame  input  1  initiator FRAME, active-high internally; 1 = transaction in progress.
- irdy  input  1  initiator ready, active-high.
- ad  input  32  multiplexed address/data bus (address sampled only).
- c_be  input  4  command (address phase) / byte enables (data phase).
- par  input  1  even parity over ad and c_be, one cycle late.
- devsel  output  1  device select, active-high, registered.
- trdy  output  1  target ready, active-high, registered.
- stop  output  1  target disconnect request, active-high, registered.
- hit_addr  output  32  latched address of the claimed transaction.
- hit_cmd  output  4  latched command of the claimed transaction.
- is_write  output  1  1 = write command claimed, 0 = read.
- data_cnt  output  4  completed data phases in the current transaction.
- perr  output  1  parity error pulse (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; devsel, trdy, stop, is_write, perr = 0; hit_addr = 0; hit_cmd = 0; data_cnt = 0. Reset mid-transaction aborts immediately; no turnaround cycle is generated.
- Address phase: the cycle where frame=1 and frame_q=0 while state=IDLE. In that cycle latch ad into hit_addr and c_be into hit_cmd.
- Accepted commands: 4'b0010 I/O read, 4'b0011 I/O write, 4'b0110 mem read, 4'b0111 mem write. is_write = c_be[0].
- Hit: address compare matches AND command is accepted.
- IDLE:
  - Address phase with hit -> DECODE; load wait counter = DEVSEL_SPEED; clear data_cnt.
  - Address phase with no hit -> BUSY.
- BUSY: outputs stay 0. Go to IDLE when frame=0 and irdy=0.
- DECODE:
  - Decrement the wait counter each cycle.
  - When it reaches 0 (immediately if DEVSEL_SPEED=0) -> DATA; devsel=1 and trdy=1 registered on the same edge.
  - With DEVSEL_SPEED=0, devsel is high in the 2nd cycle after the address phase.
- DATA:
  - Transfer occurs on a cycle with irdy=1 and trdy=1; data_cnt increments by one.
  - Transfer with frame=0 (last phase) -> TURN.
  - Transfer that makes data_cnt == MAX_BURST while frame=1 -> DISC.
  - irdy=0 holds the state; trdy stays 1 (wait state).
- DISC:
  - trdy=0, stop=1, devsel=1.
  - Hold until frame=0, then -> TURN.
  - No transfer counts in DISC.
- TURN: devsel, trdy, stop = 0 for exactly one cycle -> IDLE. hit_addr, hit_cmd and data_cnt keep their values until the next claimed address phase.
- An address phase arriving during TURN is ignored: the state goes to IDLE, and the frame edge detector misses it. The bus protocol forbids this case.
- data_cnt is 4-bit and never wraps, because MAX_BURST ≤ 15 forces DISC first.
- frame deasserting in DECODE (single-phase read) is legal. The transfer still completes in DATA because irdy=1 persists.

Optional Feature:
- Macro: PCI_PARITY_CHK_EN.
- Defined:
  - Compute even parity of the registered {ad, c_be} from each address phase and each write-data transfer.
  - Compare it against par on the following cycle.
  - perr=1 for exactly one cycle on mismatch; the check applies only while the transaction is claimed (devsel path).
- Not defined: par is ignored and perr is tied 0.

Test Plan:
- Fast single write: ad=32'h0000_1004, c_be=4'b0011, frame high 1 cycle, irdy=1 -> devsel=trdy=1 two cycles after the address phase; data_cnt=1; is_write=1; TURN lasts 1 cycle; back to IDLE.
- Miss: ad=32'h0000_2000, c_be=4'b0110 -> devsel, trdy, stop stay 0; FSM in BUSY until frame=0 and irdy=0.
- Burst disconnect: MAX_BURST=8, mem read at 32'h0000_1000, frame held high for 12 phases -> stop=1 after the 8th transfer, data_cnt=8, trdy=0 until frame drops.
- Medium decode with wait states: DEVSEL_SPEED=1, irdy toggling 1,0,1,1 with frame dropping on the 4th cycle -> devsel 3 cycles after the address phase; 3 transfers counted.
- Reset mid-burst: rst_n=0 at the 3rd data phase -> next edge all outputs 0, state IDLE, data_cnt=0.
- With PCI_PARITY_CHK_EN defined: write-data cycle with par flipped -> perr=1 for exactly one cycle. Without the macro, the same stimulus keeps perr=0.
